// File: rtl/axi_lite_mem_arbiter.sv
// 2:1 AXI4-Lite arbiter: IFU (m0, read-only) and LSU (m1, read/write) share one slave port.
// One transaction in flight; the grant is held from address issue to response handshake.
module axi_lite_mem_arbiter #(
  parameter int LSU_PRIO = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [1:0]        m1_bresp,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [1:0]        s_bresp
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD0 = 2'd1, RD1 = 2'd2, WR1 = 2'd3} state_t;

  state_t r_state;
  logic   r_last_rd;
  logic   r_ar_done;
  logic   r_aw_done;
  logic   r_w_done;

  logic   w_ar_hs;
  logic   w_aw_hs;
  logic   w_w_hs;
  logic   w_rd_done;
  logic   w_wr_done;

  assign w_ar_hs   = s_arvalid & s_arready;
  assign w_aw_hs   = s_awvalid & s_awready;
  assign w_w_hs    = s_wvalid & s_wready;
  assign w_rd_done = s_rvalid & s_rready;
  assign w_wr_done = s_bvalid & s_bready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last_rd <= 1'b0;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ar_done <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (m1_awvalid | m1_wvalid)
            r_state <= WR1;
          else if (m1_arvalid & m0_arvalid)
            r_state <= ((LSU_PRIO != 0) || !r_last_rd) ? RD1 : RD0;
          else if (m1_arvalid)
            r_state <= RD1;
          else if (m0_arvalid)
            r_state <= RD0;
        end
        RD0, RD1: begin
          // Address phases are one-shot per grant; a re-raised arvalid waits for a new grant.
          if (w_ar_hs)
            r_ar_done <= 1'b1;
          if (w_rd_done) begin
            r_state   <= IDLE;
            r_last_rd <= (r_state == RD1);
          end
        end
        WR1: begin
          if (w_aw_hs)
            r_aw_done <= 1'b1;
          if (w_w_hs)
            r_w_done <= 1'b1;
          if (w_wr_done)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = 2'b00;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = 2'b00;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = 2'b00;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = 4'b0000;
    s_bready   = 1'b0;
    case (r_state)
      RD0: begin
        s_arvalid  = m0_arvalid & ~r_ar_done;
        s_araddr   = m0_araddr;
        m0_arready = s_arready & ~r_ar_done;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        s_rready   = m0_rready;
      end
      RD1: begin
        s_arvalid  = m1_arvalid & ~r_ar_done;
        s_araddr   = m1_araddr;
        m1_arready = s_arready & ~r_ar_done;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        s_rready   = m1_rready;
      end
      WR1: begin
        s_awvalid  = m1_awvalid & ~r_aw_done;
        s_awaddr   = m1_awaddr;
        m1_awready = s_awready & ~r_aw_done;
        s_wvalid   = m1_wvalid & ~r_w_done;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        m1_wready  = s_wready & ~r_w_done;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axi_lite_mem_arbiter.md
Name: axi_lite_mem_arbiter

Overview:
- 2:1 AXI4-Lite arbiter that shares the single memory/peripheral AXI port between the instruction fetch unit (master 0, read-only) and the LSU (master 1, read and write).
- Sits between the IFU/LSU bus outputs and the SoC master port.
- Exactly one transaction is outstanding at a time; the grant is held from address issue until the response handshake completes.

Parameters:
- LSU_PRIO, 1: 1 = master 1 wins every simultaneous read request; 0 = round-robin between m0 and m1 reads.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_arvalid in 1; m0_arready out 1; m0_araddr in ADDR_W  IFU read-address channel
- m0_rvalid out 1; m0_rready in 1; m0_rdata out DATA_W; m0_rresp out 2  IFU read-data channel
- m1_arvalid in 1; m1_arready out 1; m1_araddr in ADDR_W  LSU read-address channel
- m1_rvalid out 1; m1_rready in 1; m1_rdata out DATA_W; m1_rresp out 2  LSU read-data channel
- m1_awvalid in 1; m1_awready out 1; m1_awaddr in ADDR_W  LSU write-address channel
- m1_wvalid in 1; m1_wready out 1; m1_wdata in DATA_W; m1_wstrb in 4  LSU write-data channel
- m1_bvalid out 1; m1_bready in 1; m1_bresp out 2  LSU write-response channel
- s_arvalid out 1; s_arready in 1; s_araddr out ADDR_W  slave read-address channel
- s_rvalid in 1; s_rready out 1; s_rdata in DATA_W; s_rresp in 2  slave read-data channel
- s_awvalid out 1; s_awready in 1; s_awaddr out ADDR_W  slave write-address channel
- s_wvalid out 1; s_wready in 1; s_wdata out DATA_W; s_wstrb out 4  slave write-data channel
- s_bvalid in 1; s_bready out 1; s_bresp in 2  slave write-response channel

Behaviour:
- Registered states: IDLE, RD0 (m0 read granted), RD1 (m1 read granted), WR1 (m1 write granted). A last_rd register (1 bit) records the last granted reader.
- Reset: state=IDLE, last_rd=0 (so m1 is favoured first under round-robin). Forced regardless of any in-flight transaction.
- Outputs in IDLE and during reset: every valid and ready output is 0. Payload outputs are don't-care, but a bench must not check them when the matching valid is 0.
- IDLE transition priority, evaluated each cycle:
  - m1_awvalid|m1_wvalid → WR1 (writes beat all reads).
  - Else m1_arvalid & m0_arvalid → RD1 if LSU_PRIO=1; otherwise the reader other than last_rd.
  - Else m1_arvalid → RD1.
  - Else m0_arvalid → RD0.
  - Else stay in IDLE.
- Grant latency: a request first seen in cycle N is granted in cycle N+1. s_*valid is asserted combinationally in N+1, so there is 1 cycle of arbitration overhead.
- In RDx, the granted master's AR and R channels are wired straight through to the slave:
  - s_arvalid=mx_arvalid, s_araddr=mx_araddr, mx_arready=s_arready.
  - mx_rvalid=s_rvalid, mx_rdata/rresp=s_rdata/rresp, s_rready=mx_rready.
- In WR1, m1's AW, W and B channels are wired straight through. AW and W may handshake in either order or in the same cycle.
- The non-granted master, and every channel not belonging to the current grant, sees ready=0 and valid=0. All AW/W/B slave outputs are 0 in RDx; all AR/R slave outputs are 0 in WR1.
- Release: RDx → IDLE on s_rvalid & s_rready. WR1 → IDLE on s_bvalid & s_bready. last_rd is updated to x on RDx exit.
- Turnaround: at least 1 IDLE cycle between transactions, so a master that holds its valid high is re-granted no earlier than 2 cycles after its response handshake.
- Handshake rules:
  - A master's valid, once asserted, stays held until accepted; the arbiter never asserts its ready before the grant.
  - The arbiter never drops a grant mid-transaction.
  - A second request from the granted master before its response completes is not forwarded until the grant is re-won.
- Simultaneous events:
  - m0 read, m1 read and m1 write pending together → WR1, then RD1 or RD0 per the policy.
  - A response handshake in the same cycle a new request arrives → IDLE in the next cycle, then arbitration.
- Responses are passed through unchanged, including SLVERR/DECERR; the arbiter does not count or timeout.

Test Plan:
- Single IFU read: m0_arvalid=1, araddr=0x3000_0000; slave arready in 1 cycle, rdata=0xDEADBEEF after 2 cycles → s_arvalid rises 1 cycle after m0_arvalid; m0_rdata=0xDEADBEEF, rresp=0; state IDLE the cycle after the R handshake; m1 sees no valid.
- Read collision, LSU_PRIO=1: m0 and m1 arvalid together, addresses 0x100 and 0x200 → 0x200 is forwarded first, then 0x100. m0_arready stays 0 throughout the first transaction.
- Round-robin, LSU_PRIO=0: both readers request continuously for 4 transactions → grant order m1,m0,m1,m0. Each grant begins 2 cycles after the previous R handshake.
- LSU write, W before AW: m1_wvalid (wdata=0x12345678, wstrb=4'b0011) one cycle ahead of m1_awvalid (0x8000_0004), with an m0 read pending → the write completes first with s_wstrb=0011 and m1_bvalid=1. The m0 read is issued only after the B handshake.
- Error passthrough: slave returns rresp=2'b10 to an m1 read → m1_rresp=2'b10, the grant releases normally, and a subsequent m0 read succeeds.
- Reset mid-operation: assert reset while in WR1 after AW is accepted but before B → next cycle state=IDLE, all valid/ready outputs 0. A late s_bvalid is not forwarded to m1.
